// File: rtl/lvds_rx_pkg.sv
// Shared types and helpers for the LVDS RX lane training sequencer.
// Holds the FSM encoding, word widths and the pattern expansion.
package lvds_rx_pkg;

  localparam int LVDS_WORD_W = 14;
  localparam int LVDS_PAT_W  = 7;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LANE_RST   = 3'd1,
    ST_WAIT_ALIGN = 3'd2,
    ST_VERIFY     = 3'd3,
    ST_READY      = 3'd4,
    ST_FAIL       = 3'd5
  } lvds_state_e;

  function automatic logic [LVDS_WORD_W-1:0] expand_pattern(
    input logic [LVDS_PAT_W-1:0] p
  );
    return {p, p};
  endfunction

endpackage

// File: rtl/lvds_rx_lane_verify.sv
// Per-lane word checker: strobe delay, compare, saturating match count.
// LVDS_RX_AUTO_RETRAIN_EN adds a previous-word tracker for READY monitoring.
module lvds_rx_lane_verify
  import lvds_rx_pkg::*;
#(
  parameter int VERIFY_WORDS = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   i_active,
  input  logic                   i_enable,
  input  logic [LVDS_WORD_W-1:0] i_data,
  input  logic [LVDS_WORD_W-1:0] i_expect,
  output logic                   o_done,
  output logic                   o_mismatch
`ifdef LVDS_RX_AUTO_RETRAIN_EN
  ,
  output logic                   o_bad
`endif
);

  localparam logic [7:0] CNT_MAX = 8'(VERIFY_WORDS);

  logic       r_en;
  logic [7:0] r_cnt;
  logic       w_match;

  assign w_match = (i_data == i_expect);

  // The word belonging to a strobe arrives one cycle after it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_en  <= 1'b0;
      r_cnt <= 8'd0;
    end else begin
      r_en <= i_enable;
      if (!i_active) begin
        r_cnt <= 8'd0;
      end else if (r_en && w_match && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_done     = (r_cnt == CNT_MAX);
  assign o_mismatch = r_en & ~w_match;

`ifdef LVDS_RX_AUTO_RETRAIN_EN
  logic [LVDS_WORD_W-1:0] r_prev;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_prev <= '0;
    end else if (r_en) begin
      r_prev <= i_data;
    end
  end

  // Live traffic that repeats its last word is not treated as corruption.
  assign o_bad = r_en & ~w_match & (i_data != r_prev);
`endif

endmodule

// File: rtl/lvds_rx_lane_sync_ctrl.sv
// Training sequencer for a bank of 7:1 LVDS RX lanes sharing CLK.
// Optional READY-state monitoring via LVDS_RX_AUTO_RETRAIN_EN.
module lvds_rx_lane_sync_ctrl
  import lvds_rx_pkg::*;
#(
  parameter int NUM_LANES        = 4,
  parameter int TIMEOUT_CYCLES   = 4096,
  parameter int VERIFY_WORDS     = 16,
  parameter int RST_PULSE_CYCLES = 8,
  parameter int MAX_RETRIES      = 7
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               start,
  input  logic [LVDS_PAT_W-1:0]              pattern_cfg,
  input  logic [NUM_LANES-1:0]               lane_align,
  input  logic [NUM_LANES-1:0]               lane_enable,
  input  logic [LVDS_WORD_W*NUM_LANES-1:0]   lane_data,
  output logic                               lane_rst_n,
  output logic [LVDS_PAT_W-1:0]              training_pattern,
  output logic                               rx_ready,
  output logic                               rx_fail,
  output logic [3:0]                         retry_cnt,
  output logic [NUM_LANES-1:0]               aligned_mask,
  output logic [2:0]                         state_dbg
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = $clog2(RST_PULSE_CYCLES);
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST    = RW'(RST_PULSE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  lvds_state_e             r_state;
  lvds_state_e             w_state_nxt;
  logic [TW-1:0]           r_timer;
  logic [RW-1:0]           r_rst_cnt;
  logic [3:0]              r_retry;
  logic [3:0]              w_retry_nxt;
  logic                    w_do_retry;
  logic                    r_lane_rst_n;
  logic                    r_rx_ready;
  logic                    r_rx_fail;
  logic [LVDS_PAT_W-1:0]   r_pattern;
  logic [NUM_LANES-1:0]    r_aligned;
  logic                    w_lane_rst_n_nxt;
  logic                    w_rx_ready_nxt;
  logic                    w_rx_fail_nxt;
  logic [LVDS_WORD_W-1:0]  w_expect;
  logic [NUM_LANES-1:0]    w_done;
  logic [NUM_LANES-1:0]    w_mis;
  logic                    w_all_done;
  logic                    w_any_mis;
  logic                    w_all_align;
  logic                    w_timeout;
  logic                    w_verify;

  assign w_expect    = expand_pattern(r_pattern);
  assign w_verify    = (r_state == ST_VERIFY);
  assign w_all_done  = &w_done;
  assign w_any_mis   = |w_mis;
  assign w_all_align = &lane_align;
  assign w_timeout   = (r_timer == T_LAST);

`ifdef LVDS_RX_AUTO_RETRAIN_EN
  logic [NUM_LANES-1:0] w_bad;
  logic                 w_any_bad;

  assign w_any_bad = |w_bad;
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lvds_rx_lane_verify #(
      .VERIFY_WORDS(VERIFY_WORDS)
    ) u_verify (
      .CLK       (CLK),
      .RESET     (RESET),
      .i_active  (w_verify),
      .i_enable  (lane_enable[g]),
      .i_data    (lane_data[LVDS_WORD_W*g +: LVDS_WORD_W]),
      .i_expect  (w_expect),
      .o_done    (w_done[g]),
      .o_mismatch(w_mis[g])
`ifdef LVDS_RX_AUTO_RETRAIN_EN
      ,
      .o_bad     (w_bad[g])
`endif
    );
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_do_retry  = 1'b0;
    if (!start) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_LANE_RST;
          w_retry_nxt = 4'd0;
        end
        ST_LANE_RST: begin
          if (r_rst_cnt == R_LAST) w_state_nxt = ST_WAIT_ALIGN;
        end
        ST_WAIT_ALIGN: begin
          if (w_all_align)    w_state_nxt = ST_VERIFY;
          else if (w_timeout) w_do_retry  = 1'b1;
        end
        ST_VERIFY: begin
          if (w_any_mis || !w_all_align || w_timeout) w_do_retry = 1'b1;
          else if (w_all_done) w_state_nxt = ST_READY;
        end
        ST_READY: begin
`ifdef LVDS_RX_AUTO_RETRAIN_EN
          if (!w_all_align || w_any_bad) begin
            w_state_nxt = ST_LANE_RST;
            w_retry_nxt = 4'd0;
          end
`endif
        end
        ST_FAIL: w_state_nxt = ST_FAIL;
        default: w_state_nxt = ST_IDLE;
      endcase
      if (w_do_retry) begin
        if (r_retry < RETRY_MAX) begin
          w_retry_nxt = r_retry + 4'd1;
          w_state_nxt = ST_LANE_RST;
        end else begin
          w_state_nxt = ST_FAIL;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they line up with state_dbg.
  always_comb begin
    w_lane_rst_n_nxt = 1'b0;
    w_rx_ready_nxt   = 1'b0;
    w_rx_fail_nxt    = 1'b0;
    unique case (w_state_nxt)
      ST_WAIT_ALIGN, ST_VERIFY: w_lane_rst_n_nxt = 1'b1;
      ST_READY: begin
        w_lane_rst_n_nxt = 1'b1;
        w_rx_ready_nxt   = 1'b1;
      end
      ST_FAIL: w_rx_fail_nxt = 1'b1;
      default: w_lane_rst_n_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_timer   <= '0;
      r_rst_cnt <= '0;
    end else begin
      if ((r_state == ST_WAIT_ALIGN || r_state == ST_VERIFY) &&
          (w_state_nxt == r_state)) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= '0;
      end
      if (r_state == ST_LANE_RST && w_state_nxt == ST_LANE_RST) begin
        r_rst_cnt <= r_rst_cnt + RW'(1);
      end else begin
        r_rst_cnt <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_lane_rst_n <= 1'b0;
      r_rx_ready   <= 1'b0;
      r_rx_fail    <= 1'b0;
      r_retry      <= 4'd0;
      r_pattern    <= '0;
      r_aligned    <= '0;
    end else begin
      r_lane_rst_n <= w_lane_rst_n_nxt;
      r_rx_ready   <= w_rx_ready_nxt;
      r_rx_fail    <= w_rx_fail_nxt;
      r_retry      <= w_retry_nxt;
      r_aligned    <= lane_align;
      if (r_state == ST_IDLE && start) r_pattern <= pattern_cfg;
    end
  end

  assign lane_rst_n       = r_lane_rst_n;
  assign training_pattern = r_pattern;
  assign rx_ready         = r_rx_ready;
  assign rx_fail          = r_rx_fail;
  assign retry_cnt        = r_retry;
  assign aligned_mask     = r_aligned;
  assign state_dbg        = r_state;

endmodule

// File: tb/tb_lvds_rx_lane_sync_ctrl.sv
// Self-checking bench for lvds_rx_lane_sync_ctrl (4 lanes, short timeout).
// Table-driven training runs plus hand-written retry/abort/reset sequences.
module tb_lvds_rx_lane_sync_ctrl;

  localparam int NL = 4;

  logic          CLK;
  logic          RESET;
  logic          start;
  logic [6:0]    pattern_cfg;
  logic [NL-1:0] lane_align;
  logic [NL-1:0] lane_enable;
  logic [14*NL-1:0] lane_data;
  logic          lane_rst_n;
  logic [6:0]    training_pattern;
  logic          rx_ready;
  logic          rx_fail;
  logic [3:0]    retry_cnt;
  logic [NL-1:0] aligned_mask;
  logic [2:0]    state_dbg;

  lvds_rx_lane_sync_ctrl #(
    .NUM_LANES(NL),
    .TIMEOUT_CYCLES(64),
    .VERIFY_WORDS(16),
    .RST_PULSE_CYCLES(8),
    .MAX_RETRIES(2)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .start(start),
    .pattern_cfg(pattern_cfg),
    .lane_align(lane_align),
    .lane_enable(lane_enable),
    .lane_data(lane_data),
    .lane_rst_n(lane_rst_n),
    .training_pattern(training_pattern),
    .rx_ready(rx_ready),
    .rx_fail(rx_fail),
    .retry_cnt(retry_cnt),
    .aligned_mask(aligned_mask),
    .state_dbg(state_dbg)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] cur_pat;

  // Independent monitor of LANE_RST entries and low cycles.
  int pulses = 0;
  int rstlow = 0;
  logic [2:0] mon_prev = 3'd0;
  always @(negedge CLK) begin
    if (state_dbg == 3'd1 && mon_prev != 3'd1) pulses++;
    if (state_dbg == 3'd1 && !lane_rst_n) rstlow++;
    mon_prev = state_dbg;
  end

  typedef struct {
    string      nm;
    logic [2:0] st;
    logic [3:0] rc;
    logic       rdy;
    logic       fl;
    logic       lrn;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [6:0] pat;
    int         dly;
    logic [2:0] st;
    logic [3:0] rc;
    logic       rdy;
    int         low;
  } row_t;
  row_t rows[4];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input string nm, input logic [2:0] st,
                         input logic [3:0] rc, input logic rdy,
                         input logic fl, input logic lrn);
    exp_t e;
    e.nm = nm; e.st = st; e.rc = rc;
    e.rdy = rdy; e.fl = fl; e.lrn = lrn;
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk({e.nm, "_state"}, int'(state_dbg), int'(e.st));
    chk({e.nm, "_retry"}, int'(retry_cnt), int'(e.rc));
    chk({e.nm, "_ready"}, int'(rx_ready), int'(e.rdy));
    chk({e.nm, "_fail"}, int'(rx_fail), int'(e.fl));
    chk({e.nm, "_lane_rst_n"}, int'(lane_rst_n), int'(e.lrn));
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget,
                            input string nm);
    int k = 0;
    while (state_dbg != st && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk({nm, "_reach_state"}, int'(state_dbg), int'(st));
  endtask

  task automatic wait_release(input string nm);
    int k = 0;
    while (!lane_rst_n && k < 40) begin
      @(negedge CLK);
      k++;
    end
    chk({nm, "_release"}, int'(lane_rst_n), 1);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_lane_rst_n"}, int'(lane_rst_n), 0);
    chk({nm, "_pattern"}, int'(training_pattern), 0);
    chk({nm, "_ready"}, int'(rx_ready), 0);
    chk({nm, "_fail"}, int'(rx_fail), 0);
    chk({nm, "_retry"}, int'(retry_cnt), 0);
    chk({nm, "_mask"}, int'(aligned_mask), 0);
    chk({nm, "_state"}, int'(state_dbg), 0);
  endtask

  task automatic do_reset(input bit check);
    start = 1'b0;
    pattern_cfg = 7'h0;
    lane_align = '0;
    lane_enable = '0;
    lane_data = '0;
    RESET = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    if (check) check_reset_vals("reset");
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic start_and_align(input logic [6:0] pat, input int dly,
                                 input logic [NL-1:0] alg);
    cur_pat = pat;
    pattern_cfg = pat;
    start = 1'b1;
    @(negedge CLK);
    pattern_cfg = ~pat;
    wait_release("train");
    repeat (dly) @(negedge CLK);
    lane_align = alg;
  endtask

  // Strobe every lane each cycle; lane bl carries bw for strobe bi.
  task automatic send_words(input int n, input int bl, input int bi,
                            input logic [13:0] bw, input int drop_at);
    logic [13:0] good;
    good = {cur_pat, cur_pat};
    for (int c = 0; c <= n; c++) begin
      lane_enable = (c < n) ? '1 : '0;
      for (int l = 0; l < NL; l++) begin
        lane_data[14*l +: 14] = (l == bl && c == bi + 1) ? bw : good;
      end
      if (c == drop_at) start = 1'b0;
      @(negedge CLK);
      if (state_dbg != 3'd3) break;
    end
    lane_enable = '0;
    for (int l = 0; l < NL; l++) lane_data[14*l +: 14] = good;
  endtask

  task automatic train_clean(input logic [6:0] pat, input int dly);
    start_and_align(pat, dly, '1);
    wait_state(3'd3, 5, "verify");
    send_words(16, -1, 0, 14'h0, -1);
    wait_state(3'd4, 5, "ready");
  endtask

  int p0, l0;

  initial begin
    rows[0] = '{pat: 7'b1100011, dly: 20, st: 3'd4, rc: 4'd0, rdy: 1'b1, low: 8};
    rows[1] = '{pat: 7'b0101010, dly: 3,  st: 3'd4, rc: 4'd0, rdy: 1'b1, low: 8};
    rows[2] = '{pat: 7'h7F,      dly: 0,  st: 3'd4, rc: 4'd0, rdy: 1'b1, low: 8};
    rows[3] = '{pat: 7'h00,      dly: 40, st: 3'd4, rc: 4'd0, rdy: 1'b1, low: 8};
    cur_pat = 7'h0;

    for (int r = 0; r < 4; r++) begin
      do_reset(1'b1);
      p0 = pulses;
      l0 = rstlow;
      sb_push($sformatf("row%0d", r), rows[r].st, rows[r].rc,
              rows[r].rdy, 1'b0, 1'b1);
      train_clean(rows[r].pat, rows[r].dly);
      sb_check();
      chk($sformatf("row%0d_rst_low", r), rstlow - l0, rows[r].low);
      chk($sformatf("row%0d_pulses", r), pulses - p0, 1);
      chk($sformatf("row%0d_pattern", r), int'(training_pattern),
          int'(rows[r].pat));
      chk($sformatf("row%0d_mask", r), int'(aligned_mask), 'hF);
    end

    // Lane 2 never aligns: three attempts then FAIL.
    do_reset(1'b0);
    p0 = pulses;
    l0 = rstlow;
    sb_push("noalign", 3'd5, 4'd2, 1'b0, 1'b1, 1'b0);
    start_and_align(7'h2A, 0, 4'b1011);
    wait_state(3'd5, 400, "noalign");
    sb_check();
    chk("noalign_pulses", pulses - p0, 3);
    chk("noalign_rst_low", rstlow - l0, 24);
    chk("noalign_mask", int'(aligned_mask), 'hB);
    start = 1'b0;
    @(negedge CLK);
    chk("noalign_fail_clear", int'(rx_fail), 0);
    chk("noalign_idle", int'(state_dbg), 0);

    // Lane 1 corrupts its 5th word, then a clean pass.
    do_reset(1'b0);
    start_and_align(7'b1100011, 20, '1);
    wait_state(3'd3, 5, "mis_verify");
    sb_push("mis", 3'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    send_words(16, 1, 4, 14'h0000, -1);
    sb_check();
    lane_align = '0;
    wait_release("mis_retrain");
    repeat (5) @(negedge CLK);
    lane_align = '1;
    wait_state(3'd3, 5, "mis_verify2");
    send_words(16, -1, 0, 14'h0, -1);
    wait_state(3'd4, 5, "mis_ready");
    sb_push("mis_ready", 3'd4, 4'd1, 1'b1, 1'b0, 1'b1);
    sb_check();

    // Alignment loss while READY.
    lane_align = 4'b1110;
    @(negedge CLK);
`ifdef LVDS_RX_AUTO_RETRAIN_EN
    sb_push("ready_drop", 3'd1, 4'd0, 1'b0, 1'b0, 1'b0);
`else
    repeat (3) @(negedge CLK);
    sb_push("ready_drop", 3'd4, 4'd1, 1'b1, 1'b0, 1'b1);
`endif
    sb_check();
    lane_align = '1;

    // start drops on the same cycle as a mismatch.
    do_reset(1'b0);
    p0 = pulses;
    start_and_align(7'b0011100, 10, '1);
    wait_state(3'd3, 5, "abort_verify");
    sb_push("abort", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    send_words(16, 1, 4, 14'h0000, 5);
    sb_check();
    repeat (5) @(negedge CLK);
    chk("abort_no_rst_entry", pulses - p0, 1);
    chk("abort_stay_idle", int'(state_dbg), 0);

    // Async reset while READY.
    do_reset(1'b0);
    train_clean(7'b1010101, 5);
    chk("pre_reset_ready", int'(rx_ready), 1);
    #2;
    RESET = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(negedge CLK);
    RESET = 1'b1;
    start = 1'b0;
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
